// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among N_REQ requesters.
// Ports: req_* (valid/ready operation in), alu_* (shared ALU drive/return),
//        rsp_* (valid/ready response out), busy (state != IDLE).
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_sel,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int CW = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [ID_W-1:0] next_ptr;

    // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        logic [CW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        alu_a   <= req_a[winner*WIDTH +: WIDTH];
                        alu_b   <= req_b[winner*WIDTH +: WIDTH];
                        alu_sel <= req_sel[winner*3 +: 3];
                        op_id   <= winner;
                        rr_ptr  <= next_ptr;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= op_id;
                    rsp_err    <= (alu_sel > 3'b100);
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural stand-in for the ALU.
// Requesters hold valid/data until accepted; responses checked in order.
module tb_alu_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*3-1:0]     req_sel;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [2:0]             alu_sel;
    logic [WIDTH-1:0]       alu_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_err;
    logic                   busy;

    alu_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy)
    );

    // shared ALU stand-in
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] res;
        logic       err;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    int   grant_log[$];
    int   reload[N_REQ];
    logic [N_REQ-1:0] acc_mask;
    int   exp_ptr;
    int   cyc, acc_cyc, rsp_cnt;
    int   last_id;
    logic [3:0] last_res;
    logic last_err;
    logic hold, prev_v;
    logic [3:0] sv_res;
    logic [1:0] sv_id;
    logic sv_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_ref(logic [3:0] a, logic [3:0] b,
                                           logic [2:0] s);
        logic [4:0] t;
        t = 5'd0;
        if (s == 3'd0) t = {1'b0, a} + {1'b0, b};
        if (s == 3'd1) t = {1'b0, a} + {1'b0, ~b} + 5'd1;
        if (s == 3'd2) t = {1'b0, a & b};
        if (s == 3'd3) t = {1'b0, a | b};
        if (s == 3'd4) t = {1'b0, a ^ b};
        return t[3:0];
    endfunction

    function automatic int rr_pick(logic [N_REQ-1:0] v, int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(logic [N_REQ-1:0] v);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic present(int i, logic [3:0] a, logic [3:0] b,
                           logic [2:0] s, int more);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_sel[i*3 +: 3]       = s;
        req_valid[i]            = 1'b1;
        reload[i]               = more;
    endtask

    // driver: after an accept edge, retire or reload each requester
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_mask[i]) begin
                    if (reload[i] > 0) begin
                        present(i, 4'($urandom), 4'($urandom),
                                3'($urandom_range(0, 7)), reload[i] - 1);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            acc_mask = '0;
        end
    end

    // monitor: arbitration model, scoreboard and hold checks
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb.delete();
                exp_ptr = 0;
                hold    = 1'b0;
                prev_v  = 1'b0;
            end else begin
                if (!busy) chk("idle_grant", 32'(req_ready != 0),
                               32'(req_valid != 0));
                if (busy) chk("busy_no_grant", 32'(req_ready), 0);
                if (req_ready != 0) begin
                    int w, g;
                    rsp_t e;
                    chk("ready_onehot", 32'($onehot(req_ready)), 1);
                    chk("ready_valid", 32'(req_ready & ~req_valid), 0);
                    w = rr_pick(req_valid, exp_ptr);
                    g = idx_of(req_ready);
                    chk("grant_id", g, w);
                    if (g >= 0) begin
                        exp_ptr = (g + 1) % N_REQ;
                        e.id  = g;
                        e.res = alu_ref(req_a[g*WIDTH +: WIDTH],
                                        req_b[g*WIDTH +: WIDTH],
                                        req_sel[g*3 +: 3]);
                        e.err = (req_sel[g*3 +: 3] > 3'd4);
                        sb.push_back(e);
                        grant_log.push_back(g);
                        acc_cyc = cyc;
                        acc_mask[g] = 1'b1;
                    end
                end
                if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, 2);
                if (hold) begin
                    chk("hold_valid", 32'(rsp_valid), 1);
                    chk("hold_result", 32'(rsp_result), 32'(sv_res));
                    chk("hold_id", 32'(rsp_id), 32'(sv_id));
                    chk("hold_err", 32'(rsp_err), 32'(sv_err));
                end
                if (rsp_valid && rsp_ready) begin
                    chk("sb_level", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        rsp_t e;
                        e = sb.pop_front();
                        chk("rsp_id", 32'(rsp_id), e.id);
                        chk("rsp_result", 32'(rsp_result), 32'(e.res));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    last_id  = int'(rsp_id);
                    last_res = rsp_result;
                    last_err = rsp_err;
                    rsp_cnt++;
                end
                hold   = rsp_valid && !rsp_ready;
                sv_res = rsp_result;
                sv_id  = rsp_id;
                sv_err = rsp_err;
                prev_v = rsp_valid;
            end
        end
    end

    task automatic chk_reset_outs();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    task automatic wait_rsp(int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rsp_timeout", 32'(rsp_cnt >= target), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) reload[i] = 0;
        repeat (2) @(negedge clk);
        #2;
        grant_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic do_op(int i, logic [3:0] a, logic [3:0] b, logic [2:0] s,
                         logic [3:0] er, logic ee);
        @(posedge clk);
        #1;
        present(i, a, b, s, 0);
        wait_rsp(rsp_cnt + 1);
        chk("op_result", 32'(last_res), 32'(er));
        chk("op_err", 32'(last_err), 32'(ee));
        chk("op_id", last_id, i);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sel = '0;
        rsp_ready = 1'b1;
        acc_mask = '0;
        exp_ptr = 0;
        cyc = 0;
        acc_cyc = 0;
        rsp_cnt = 0;
        hold = 1'b0;
        prev_v = 1'b0;
        for (int i = 0; i < N_REQ; i++) reload[i] = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs();
        #1;
        rst_n = 1'b1;

        // single op and arithmetic corners
        do_op(0, 4'h3, 4'h5, 3'b000, 4'h8, 1'b0);
        do_op(1, 4'hF, 4'h1, 3'b000, 4'h0, 1'b0);
        do_op(2, 4'h2, 4'h5, 3'b001, 4'hD, 1'b0);
        do_op(3, 4'hC, 4'hA, 3'b010, 4'h8, 1'b0);
        do_op(0, 4'hC, 4'hA, 3'b011, 4'hE, 1'b0);
        do_op(1, 4'hC, 4'hA, 3'b100, 4'h6, 1'b0);
        do_op(2, 4'h9, 4'h9, 3'b111, 4'h0, 1'b1);

        // fairness from reset
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            present(i, 4'($urandom), 4'($urandom),
                    3'($urandom_range(0, 7)), 1);
        end
        wait_rsp(rsp_cnt + 8);
        chk("fair_len", grant_log.size(), 8);
        if (grant_log.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk("fair_order", grant_log[k], k % 4);
        end

        // backpressure
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        present(1, 4'h7, 4'h4, 3'b001, 0);
        present(2, 4'h6, 4'h3, 3'b011, 0);
        present(3, 4'h5, 4'h5, 3'b100, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_busy", 32'(busy), 1);
            chk("bp_no_grant", 32'(req_ready), 0);
            chk("bp_valid", 32'(rsp_valid), 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("bp_idle", 32'(busy), 0);
        chk("bp_regrant", 32'(req_ready != 0), 1);
        wait_rsp(rsp_cnt + 2);

        // reset during EXEC
        @(posedge clk);
        #1;
        present(2, 4'h1, 4'h1, 3'b000, 0);
        n = 0;
        while (!(busy && !rsp_valid) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_exec_seen", 32'(busy && !rsp_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) reload[i] = 0;
        repeat (2) @(negedge clk);
        #2;
        grant_log.delete();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("no_stale_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        present(1, 4'h4, 4'h2, 3'b000, 0);
        present(3, 4'h1, 4'h2, 3'b000, 0);
        wait_rsp(rsp_cnt + 2);
        chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 4-bit `alu` instance among `N_REQ` requesters. It accepts one operation (a, b, sel) at a time from a requester, drives the shared ALU from registered operands, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between the requesting units and the single `alu` datapath, which it instantiates alongside itself at the parent level.

## Interface
- `N_REQ`, 4, number of requesters (2..8); `ID_W = $clog2(N_REQ)` derived internally
- `WIDTH`, 4, operand/result width (must match `alu`)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  N_REQ  per-requester operation pending
- `req_a`  in  N_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  packed operand B, same packing
- `req_sel`  in  N_REQ*3  packed ALU select, requester i at [i*3 +: 3]
- `req_ready`  out  N_REQ  one-hot accept pulse; operation i taken when `req_valid[i] & req_ready[i]`
- `alu_a`, `alu_b`  out  WIDTH  registered operands to shared ALU
- `alu_sel`  out  3  registered select to shared ALU
- `alu_result`  in  WIDTH  combinational result from shared ALU
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  ID_W  index of requester that issued the operation
- `rsp_result`  out  WIDTH  captured ALU result
- `rsp_err`  out  1  sel was 3'b101..3'b111 (unsupported op)
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid` set, pick winner by round-robin starting from `rr_ptr`; assert `req_ready[winner]` combinationally this cycle; latch winner's a/b/sel into `alu_a/alu_b/alu_sel`, latch winner into `op_id`; set `rr_ptr <= (winner+1) mod N_REQ`; go EXEC. No request: stay IDLE, `req_ready` all 0.
- EXEC: ALU inputs stable from registers; at end of cycle capture `alu_result` into `rsp_result`, `op_id` into `rsp_id`, `rsp_err = (alu_sel > 3'b100)`; go RESP.
- RESP: `rsp_valid=1`; outputs held stable until `rsp_ready`; on `rsp_valid & rsp_ready` go IDLE and clear `rsp_valid`. No new grant while in EXEC or RESP.
- Arithmetic: modulo 2^WIDTH, no carry/borrow out; unsupported sel yields ALU result 0 plus `rsp_err=1`.
- `req_ready` is only ever one-hot or zero; never asserted to a requester with `req_valid=0`.
- `req_*` data of non-winners ignored; requesters hold valid and data until accepted.

## Timing
- Reset (async, `rst_n=0`): state IDLE, `rr_ptr=0`, `req_ready=0`, `alu_a=alu_b=0`, `alu_sel=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_err=0`, `busy=0`. Reset mid-EXEC or mid-RESP discards the operation; no response is produced.
- Latency: accept at cycle t (IDLE) -> `rsp_valid` high from cycle t+2.
- Throughput: one op per 3 cycles with `rsp_ready` held high (accept, exec, respond; IDLE re-arbitrates the cycle after response handshake).
- Wrap: `rr_ptr` rolls from N_REQ-1 to 0; search order is ptr, ptr+1, …, wrapping.
- Simultaneous requests: exactly one grant per arbitration, lowest index at/after `rr_ptr`.
- Backpressure: `rsp_*` must not change while `rsp_valid & !rsp_ready`.

## Test plan
- Single op: req 0 valid, a=3, b=5, sel=000, `rsp_ready=1` -> `req_ready[0]` pulse at t, `rsp_valid` at t+2, `rsp_result=4'h8`, `rsp_id=0`, `rsp_err=0`.
- Wrap arithmetic: a=F, b=1, sel=000 -> result 0; a=2, b=5, sel=001 -> 4'hD; a=C, b=A, sel=010/011/100 -> 8 / E / 6.
- Fairness: all four requesters valid continuously from reset -> grants in order 0,1,2,3,0,1; each response carries matching `rsp_id`; no grant during EXEC/RESP.
- Backpressure: hold `rsp_ready=0` for 5 cycles with others requesting -> `rsp_valid`, `rsp_result`, `rsp_id` stable, `req_ready` all 0, `busy=1`; release -> IDLE next cycle, next grant the cycle after.
- Illegal op: sel=3'b111, a=9, b=9 -> `rsp_result=0`, `rsp_err=1`.
- Reset mid-op: drop `rst_n` during EXEC -> all outputs reset immediately; after release, no stale `rsp_valid`; next request served from `rr_ptr=0`.
